// File: rtl/wb_initiator_pkg.sv
// rtl/wb_initiator_pkg.sv - shared state encodings and defaults for the Wishbone initiator
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int WB_AW_DEFAULT = 32;
  localparam int WB_DW_DEFAULT = 32;

  // Read data returned for writes and timed-out cycles; sliced to DW by users.
  localparam logic [63:0] WB_ERR_DAT = '0;

endpackage

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic single-cycle master with valid/ready command and response ports
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = WB_AW_DEFAULT,
  parameter int DW      = WB_DW_DEFAULT
) (
  input  logic            wb_clk_i,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i,
  output logic            busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wb_state_e       state, state_d;
  logic            cyc_d, we_d, rsp_valid_d, rsp_err_d;
  logic [DW/8-1:0] sel_d;
  logic [AW-1:0]   adr_d;
  logic [DW-1:0]   dat_d, rsp_dat_d;
  logic [CW-1:0]   cnt, cnt_d;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign wbm_stb_o = wbm_cyc_o;

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      wbm_cyc_o <= cyc_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_dat   <= rsp_dat_d;
      cnt       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    cyc_d       = wbm_cyc_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_dat_d   = rsp_dat;
    cnt_d       = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack arriving on the timeout edge still completes the cycle normally.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = wbm_we_o ? WB_ERR_DAT[DW-1:0] : wbm_dat_i;
          state_d     = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = WB_ERR_DAT[DW-1:0];
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized self-checking bench for wb_initiator against a transaction-level model
module tb_wb_initiator;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT(TIMEOUT), .AW(32), .DW(32)) dut (
    .wb_clk_i(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The slave acks in the (wait_n+1)-th cycle of CYC; the model predicts
  // the cycle length and response purely from wait_n versus TIMEOUT.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata,
                         input int wait_n, input int bp);
    int          cyc_cnt;
    int          exp_cycles;
    logic        exp_err;
    logic [31:0] exp_dat;
    bit          done;
    exp_err    = (wait_n >= TIMEOUT);
    exp_cycles = exp_err ? TIMEOUT : wait_n + 1;
    exp_dat    = (exp_err || we) ? 32'h0 : rdata;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    step();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

    check("cyc_start", wbm_cyc_o, 1);
    check("stb_start", wbm_stb_o, 1);
    check("we_out", wbm_we_o, we);
    check("adr_out", wbm_adr_o, adr);
    check("dat_out", wbm_dat_o, dat);
    check("sel_out", wbm_sel_o, sel);
    check("cmd_ready_bus", cmd_ready, 0);
    check("busy_bus", busy, 1);

    cyc_cnt = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (wbm_cyc_o) begin
        cyc_cnt++;
        wbm_ack_i = (cyc_cnt == wait_n + 1);
        wbm_dat_i = wbm_ack_i ? rdata : $urandom;
        step();
        wbm_ack_i = 1'b0;
      end else begin
        done = 1;
      end
    end
    check("cyc_bound", done, 1);
    check("cyc_cycles", cyc_cnt, exp_cycles);
    check("stb_end", wbm_stb_o, 0);
    check("rsp_valid_first", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_dat", rsp_dat, exp_dat);

    rsp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      wbm_ack_i = 1'($urandom);
      wbm_dat_i = $urandom;
      step();
      wbm_ack_i = 1'b0;
      check("bp_valid", rsp_valid, 1);
      check("bp_err", rsp_err, exp_err);
      check("bp_dat", rsp_dat, exp_dat);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_done", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat_o", wbm_dat_o, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    run_txn(1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'hF, 32'h0, 0, 0);
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'h1234_5678, 3, 0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 32'hDEAD_BEEF, 100, 0);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_F00D, 1, 5);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h0BAD_CAFE, TIMEOUT - 1, 0);
    run_txn(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h1, 32'h0, TIMEOUT - 1, 1);

    // Stray acks while idle must not start anything.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    repeat (3) begin
      step();
      check("stray_busy", busy, 0);
      check("stray_cyc", wbm_cyc_o, 0);
      check("stray_rsp_valid", rsp_valid, 0);
      check("stray_cmd_ready", cmd_ready, 1);
    end
    wbm_ack_i = 1'b0;

    // Reset pulse in the middle of a bus cycle.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_rst_cyc", wbm_cyc_o, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 0);
    check("mid_rst_stb", wbm_stb_o, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    step();
    reset_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_busy", busy, 0);
    end

    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
              int'($urandom_range(0, TIMEOUT + 3)), int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
